// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-step shift/rotate unit with start/busy/done handshake, carry and zero flags
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               msb_in,
  input  logic               lsb_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out,
  output logic               zero,
  output logic               busy,
  output logic               done
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]         state;
  logic [2:0]         op_r;
  logic [SHAMT_W-1:0] cnt;
  logic               msb_r, lsb_r;
  logic [WIDTH-1:0]   step_d;
  logic               step_c;
  always_comb begin
    step_d = data_out;
    case (op_r)
      3'd2: step_d = {msb_r, data_out[WIDTH-1:1]};
      3'd3: step_d = {data_out[WIDTH-2:0], lsb_r};
      3'd4: step_d = {data_out[0], data_out[WIDTH-1:1]};
      3'd5: step_d = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
      3'd6: step_d = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
      3'd7: step_d = {data_out[WIDTH-2:0], 1'b0};
      default: step_d = data_out;
    endcase
    step_c = op_r[0] ? data_out[WIDTH-1] : data_out[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_out  <= '0;
      carry_out <= 1'b0;
      cnt       <= '0;
      op_r      <= '0;
      msb_r     <= 1'b0;
      lsb_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (op == 3'd1) begin
            data_out  <= data_in;
            carry_out <= 1'b0;
            state     <= DONE;
          end else if (op == 3'd0 || shamt == '0) begin
            state <= DONE;
          end else begin
            op_r  <= op;
            cnt   <= shamt;
            msb_r <= msb_in;
            lsb_r <= lsb_in;
            state <= RUN;
          end
        end
        RUN: begin
          data_out  <= step_d;
          carry_out <= step_c;
          cnt       <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign zero = data_out == '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven vectors plus hand sequences for handshake, intermediates and abort
module tb_shift_sequencer;
  logic       clk = 0, rst = 0, start = 0, msb_in = 0, lsb_in = 0;
  logic [2:0] op = 0, shamt = 0;
  logic [7:0] data_in = 0, data_out;
  logic       carry_out, zero, busy, done;
  int total = 0, bad = 0;

  shift_sequencer #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .shamt(shamt), .data_in(data_in),
    .msb_in(msb_in), .lsb_in(lsb_in), .data_out(data_out), .carry_out(carry_out),
    .zero(zero), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] shamt;
    logic [7:0] din;
    logic       msb, lsb;
    logic [7:0] ed;
    logic       ec;
    int         lat;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [2:0] s, input logic [7:0] d, input logic m, input logic l);
    @(negedge clk);
    op = o; shamt = s; data_in = d; msb_in = m; lsb_in = l; start = 1;
    @(negedge clk);
    start = 0; op = 0; shamt = 0; data_in = 8'hXX; msb_in = ~m; lsb_in = ~l;
  endtask

  task automatic run_op(input string n, input vec_t v);
    int cyc;
    issue(v.op, v.shamt, v.din, v.msb, v.lsb);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({n, "_done"}, done, 1);
    chk({n, "_lat"}, cyc, v.lat);
    chk({n, "_data"}, data_out, v.ed);
    chk({n, "_carry"}, carry_out, v.ec);
    chk({n, "_zero"}, zero, v.ed == 0);
    @(negedge clk);
    chk({n, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int dones, first;
    vt[0] = '{3'd1, 3'd0, 8'hA5, 0, 0, 8'hA5, 0, 1};
    vt[1] = '{3'd5, 3'd4, 8'h00, 0, 0, 8'h5A, 0, 5};
    vt[2] = '{3'd1, 3'd6, 8'h84, 0, 0, 8'h84, 0, 1};
    vt[3] = '{3'd6, 3'd2, 8'h00, 0, 0, 8'hE1, 0, 3};
    vt[4] = '{3'd1, 3'd0, 8'h80, 0, 0, 8'h80, 0, 1};
    vt[5] = '{3'd7, 3'd1, 8'h00, 0, 1, 8'h00, 1, 2};
    vt[6] = '{3'd0, 3'd3, 8'hFF, 1, 1, 8'h00, 1, 1};
    vt[7] = '{3'd2, 3'd0, 8'hFF, 1, 1, 8'h00, 1, 1};
    vt[8] = '{3'd3, 3'd2, 8'h00, 0, 1, 8'h03, 0, 3};

    rst = 1; start = 1; op = 1; data_in = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_flags", {carry_out, busy, done, zero}, 4'b0001);
    rst = 0; start = 0; op = 0;

    run_op("load_a5", vt[0]);
    issue(3'd2, 3'd3, 8'h00, 1, 0);
    chk("fill_e0", {busy, done, data_out}, {2'b10, 8'hA5});
    @(negedge clk); chk("fill_e1", {carry_out, data_out}, {1'b1, 8'hD2});
    @(negedge clk); chk("fill_e2", {carry_out, data_out}, {1'b0, 8'hE9});
    @(negedge clk); chk("fill_e3", {busy, done, carry_out, data_out}, {3'b111, 8'hF4});
    @(negedge clk); chk("fill_e4", {busy, done}, 2'b00);

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vt[i]);

    issue(3'd4, 3'd7, 8'h00, 0, 0);
    dones = 0; first = 0;
    for (int c = 1; c < 20; c++) begin
      if (c == 3) begin op = 4; shamt = 7; start = 1; end
      if (c == 4) start = 0;
      if (done) begin dones++; if (first == 0) first = c; end
      @(negedge clk);
    end
    chk("busy_dones", dones, 1);
    chk("busy_lat", first, 8);
    chk("busy_data", {carry_out, data_out}, {1'b0, 8'h06});

    vt[0].din = 8'h01; vt[0].ed = 8'h01;
    run_op("load_01", vt[0]);
    issue(3'd4, 3'd7, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    chk("abort_mid", {busy, data_out}, {1'b1, 8'h20});
    rst = 1;
    @(negedge clk);
    rst = 0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk("abort_quiet", dones, 0);
    chk("abort_data", {carry_out, data_out}, 9'h000);
    vt[0].din = 8'h5A; vt[0].ed = 8'h5A;
    run_op("post_rst", vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
